// File: rtl/fa_pkg.sv
// Shared definitions for the serial subtractor: FSM states, default width,
// and the bit-counter sizing helper.
// Imported by serial_sub and its per-bit cell.
package fa_pkg;

  // Default operand/result width of the serial subtractor.
  localparam int DEF_WIDTH = 8;

  // Controller states: waiting for work, shifting bits, presenting a result.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Counter width able to hold every value from 0 up to and including w,
  // so the bit counter never wraps inside one operation.
  function automatic int cnt_bits(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/fs_bit.sv
// Single-bit full subtractor cell: d = x - y - bin, with borrow out.
// Purely combinational, zero latency.
// No handshake; the caller owns all state.
module fs_bit (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);

  // Difference bit and borrow-out of one subtractor stage.
  always_comb begin
    d    = x ^ y ^ bin;
    bout = (~x & y) | (~(x ^ y) & bin);
  end

endmodule

// File: rtl/serial_sub.sv
// Bit-serial subtractor: d = x - y mod 2^WIDTH, bout = (x < y), LSB first.
// Latency WIDTH+1 cycles from the accepting edge to done; one op in flight.
// start is honoured only while ready=1; it is ignored in RUN and DONE.
module serial_sub
  import fa_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             ck,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             ready,
  output logic [WIDTH-1:0] d,
  output logic             bout,
  output logic             done
);

  localparam int CW = cnt_bits(WIDTH);

  state_t           state;
  state_t           state_nxt;

  logic [WIDTH-1:0] xs;
  logic [WIDTH-1:0] ys;
  logic [WIDTH-1:0] res;
  logic [WIDTH-1:0] res_shift;
  logic             borrow;
  logic [CW-1:0]    cnt;

  logic             diff_bit;
  logic             borrow_nxt;
  logic             last_bit;
  logic             accept;

  // One subtractor cell, fed by the low bits of the operand shifters and
  // the running borrow.
  fs_bit u_cell (
    .x    (xs[0]),
    .y    (ys[0]),
    .bin  (borrow),
    .d    (diff_bit),
    .bout (borrow_nxt)
  );

  // Decode the bit position and the handshake from the current state.
  always_comb begin
    last_bit  = (cnt == CW'(WIDTH - 1));
    accept    = (state == IDLE) && start;
    // New difference bit enters at the MSB end so that, after WIDTH shifts,
    // the first computed bit has landed in bit 0.
    res_shift = (res >> 1) | (WIDTH'(diff_bit) << (WIDTH - 1));
  end

  // State register.
  always_ff @(posedge ck or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic and the state-decoded status outputs.
  always_comb begin
    state_nxt = state;
    ready     = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (start) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (last_bit) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Operand shifters, borrow flop, result shifter and bit counter.
  always_ff @(posedge ck or negedge rst) begin
    if (!rst) begin
      xs     <= '0;
      ys     <= '0;
      res    <= '0;
      borrow <= 1'b0;
      cnt    <= '0;
    end else if (accept) begin
      xs     <= x;
      ys     <= y;
      res    <= '0;
      borrow <= 1'b0;
      cnt    <= '0;
    end else if (state == RUN) begin
      xs     <= xs >> 1;
      ys     <= ys >> 1;
      res    <= res_shift;
      borrow <= borrow_nxt;
      // Stops at WIDTH on the final bit, which CW bits can always hold.
      cnt    <= cnt + CW'(1);
    end
  end

  // Publish the finished result on the edge that enters DONE; hold it until
  // the next completed operation so partial results are never visible.
  always_ff @(posedge ck or negedge rst) begin
    if (!rst) begin
      d    <= '0;
      bout <= 1'b0;
    end else if ((state == RUN) && last_bit) begin
      d    <= res_shift;
      bout <= borrow_nxt;
    end
  end

endmodule

// File: tb/tb_serial_sub.sv
// Scoreboard bench for serial_sub (WIDTH=8): expected results are queued
// when an operation is accepted and compared when done pulses.
// Covers directed cases, continuous start, mid-run reset and random ops.
module tb_serial_sub;
  import fa_pkg::*;

  localparam int W = 8;

  logic         ck;
  logic         rst;
  logic         start;
  logic [W-1:0] x;
  logic [W-1:0] y;
  logic         ready;
  logic [W-1:0] d;
  logic         bout;
  logic         done;

  typedef struct {
    logic [W-1:0] d;
    logic         b;
    int           acc;
  } exp_t;

  exp_t         sb[$];
  int           checks;
  int           errors;
  int           cyc;
  int           last_acc;
  bit           cont_phase;
  logic [W-1:0] last_d;
  logic         last_b;

  serial_sub #(.WIDTH(W)) dut (
    .ck    (ck),
    .rst   (rst),
    .start (start),
    .x     (x),
    .y     (y),
    .ready (ready),
    .d     (d),
    .bout  (bout),
    .done  (done)
  );

  initial ck = 1'b0;
  always #5 ck = ~ck;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  always @(posedge ck) cyc++;

  // Monitor: sample away from the active edge, queue accepted ops, score done.
  always @(negedge ck) begin
    if (rst) begin
      if (done) begin
        check_eq("done_expected", 32'(sb.size() > 0), 32'd1);
        check_eq("ready_in_done", 32'(ready), 32'd0);
        if (sb.size() > 0) begin
          exp_t e;
          e = sb.pop_front();
          check_eq("d", 32'(d), 32'(e.d));
          check_eq("bout", 32'(bout), 32'(e.b));
          check_eq("latency", 32'(cyc - e.acc + 1), 32'(W + 1));
        end
        last_d = d;
        last_b = bout;
      end else begin
        check_eq("d_hold", 32'(d), 32'(last_d));
        check_eq("bout_hold", 32'(bout), 32'(last_b));
      end
      if (ready && start) begin
        logic [W:0] full;
        exp_t       n;
        full  = {1'b0, x} - {1'b0, y};
        n.d   = full[W-1:0];
        n.b   = (x < y);
        n.acc = cyc + 1;
        if (cont_phase && last_acc >= 0)
          check_eq("spacing", 32'(n.acc - last_acc), 32'(W + 2));
        last_acc = n.acc;
        sb.push_back(n);
      end
    end
  end

  // Wait (bounded) for ready while poking start/operands that must be ignored,
  // then present one operation for exactly one accepting edge.
  task automatic op(input logic [W-1:0] xa, input logic [W-1:0] ya);
    int n;
    n = 0;
    while (!ready && n < 50) begin
      start = 1'($urandom_range(0, 1));
      x     = W'($urandom);
      y     = W'($urandom);
      @(posedge ck);
      #1;
      n++;
    end
    check_eq("ready_timeout", 32'(ready), 32'd1);
    start = 1'b1;
    x     = xa;
    y     = ya;
    @(posedge ck);
    #1;
    start = 1'b0;
    x     = W'($urandom);
    y     = W'($urandom);
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    cyc        = 0;
    last_acc   = -1;
    cont_phase = 1'b0;
    last_d     = '0;
    last_b     = 1'b0;
    rst        = 1'b0;
    start      = 1'b0;
    x          = '0;
    y          = '0;

    #1;
    check_eq("rst_ready", 32'(ready), 32'd1);
    check_eq("rst_d", 32'(d), 32'd0);
    check_eq("rst_bout", 32'(bout), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);

    repeat (3) @(posedge ck);
    #1;
    // Release reset with start already up: the very next edge must accept.
    rst = 1'b1;
    op(8'h35, 8'h12);
    op(8'h12, 8'h35);
    op(8'h00, 8'h01);
    op(8'hA5, 8'hA5);
    op(8'h00, 8'hFF);
    op(8'hFF, 8'h00);

    // Continuous start with operands changing every cycle.
    op(8'h01, 8'h02);
    while (!ready) begin
      @(posedge ck);
      #1;
    end
    last_acc   = -1;
    cont_phase = 1'b1;
    start      = 1'b1;
    repeat (45) begin
      x = W'($urandom);
      y = W'($urandom);
      @(posedge ck);
      #1;
    end
    start      = 1'b0;
    cont_phase = 1'b0;

    // Asynchronous reset four cycles into RUN.
    op(8'h77, 8'h11);
    repeat (3) @(posedge ck);
    #2;
    rst = 1'b0;
    #1;
    sb.delete();
    last_d = '0;
    last_b = 1'b0;
    check_eq("midrst_ready", 32'(ready), 32'd1);
    check_eq("midrst_d", 32'(d), 32'd0);
    check_eq("midrst_bout", 32'(bout), 32'd0);
    check_eq("midrst_done", 32'(done), 32'd0);
    @(posedge ck);
    #1;
    check_eq("midrst_done_hold", 32'(done), 32'd0);
    rst = 1'b1;
    @(posedge ck);
    #1;
    op(8'h9C, 8'h3B);

    // Random operations against the reference model.
    for (int i = 0; i < 1000; i++) begin
      op(W'($urandom), W'($urandom));
    end

    begin
      int n;
      n = 0;
      while (sb.size() != 0 && n < 40) begin
        @(posedge ck);
        #1;
        n++;
      end
      check_eq("drain", 32'(sb.size()), 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
